apb_rtc_alarm: RTL

APB_RTC_ALARM -- requirements
Module: apb_rtc_alarm

---
 rtl/apb_rtc_alarm.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/apb_rtc_alarm.sv
// apb_rtc_alarm: APB real-time counter with programmable prescaler and
// NUM_ALARMS match channels feeding a masked, registered interrupt.
// Optional feature macro: APB_RTC_OVF_IRQ_EN adds status bit NUM_ALARMS,
// which is set when the counter wraps from all-ones to zero.
//
// Register map (word index = PADDR[ADDR_WIDTH-1:2]):
//   0x000 DR   counter (read-only)
//   0x004 LR   write loads the counter (reads as 0)
//   0x008 CR   bit0 EN
//   0x00C PSR  prescale value
//   0x010 IMSC interrupt mask
//   0x014 RIS  raw status (read-only)
//   0x018 MIS  RIS & IMSC (read-only)
//   0x01C ICR  write-1-to-clear RIS (reads as 0)
//   0x100+4n   MR[n] match value
module apb_rtc_alarm #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_ALARMS     = 4,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  INTR
);

    // Word address width and status width (alarms plus overflow slot).
    localparam int AW = ADDR_WIDTH - 2;
    localparam int SW = NUM_ALARMS + 1;

    localparam logic [AW-1:0] A_DR   = AW'(0);
    localparam logic [AW-1:0] A_LR   = AW'(1);
    localparam logic [AW-1:0] A_CR   = AW'(2);
    localparam logic [AW-1:0] A_PSR  = AW'(3);
    localparam logic [AW-1:0] A_IMSC = AW'(4);
    localparam logic [AW-1:0] A_RIS  = AW'(5);
    localparam logic [AW-1:0] A_MIS  = AW'(6);
    localparam logic [AW-1:0] A_ICR  = AW'(7);
    localparam logic [AW-1:0] A_MR0  = AW'(64);

    // Status bits that physically exist; the overflow slot reads as 0
    // and ignores writes when the overflow interrupt is not built in.
`ifdef APB_RTC_OVF_IRQ_EN
    localparam logic [SW-1:0] STAT_MASK = {SW{1'b1}};
`else
    localparam logic [SW-1:0] STAT_MASK = {1'b0, {NUM_ALARMS{1'b1}}};
`endif

    // ---------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------
    logic [AW-1:0]         word_addr;
    logic                  access;
    logic                  sel_dr, sel_lr, sel_cr, sel_psr;
    logic                  sel_imsc, sel_ris, sel_mis, sel_icr;
    logic [NUM_ALARMS-1:0] mr_sel;
    logic                  mapped;
    logic                  ro_sel;
    logic                  wr_ok;
    logic                  lr_wr, cr_wr, psr_wr, imsc_wr, icr_wr;
    logic                  unused_addr_lsbs;

    assign word_addr        = PADDR[ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = ^PADDR[1:0];
    assign access           = PSEL & PENABLE;

    assign sel_dr   = (word_addr == A_DR);
    assign sel_lr   = (word_addr == A_LR);
    assign sel_cr   = (word_addr == A_CR);
    assign sel_psr  = (word_addr == A_PSR);
    assign sel_imsc = (word_addr == A_IMSC);
    assign sel_ris  = (word_addr == A_RIS);
    assign sel_mis  = (word_addr == A_MIS);
    assign sel_icr  = (word_addr == A_ICR);

    assign mapped = sel_dr | sel_lr | sel_cr | sel_psr | sel_imsc |
                    sel_ris | sel_mis | sel_icr | (|mr_sel);

    // Registers that reject writes with an error response.
    assign ro_sel = sel_dr | sel_ris | sel_mis;

    // A write commits only when it is legal; illegal writes change nothing.
    assign wr_ok   = access & PWRITE & mapped & ~ro_sel;
    assign lr_wr   = wr_ok & sel_lr;
    assign cr_wr   = wr_ok & sel_cr;
    assign psr_wr  = wr_ok & sel_psr;
    assign imsc_wr = wr_ok & sel_imsc;
    assign icr_wr  = wr_ok & sel_icr;

    // Zero wait states; error is only flagged in the access phase and is
    // held low while reset is asserted.
    assign PREADY  = 1'b1;
    assign PSLVERR = PRESETn & access & (~mapped | (PWRITE & ro_sel));

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [DATA_WIDTH-1:0]     cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [PRESCALE_WIDTH-1:0] psr_q, psr_d;
    logic                      en_q, en_d;
    logic [SW-1:0]             imsc_q, imsc_d;
    logic [SW-1:0]             ris_q, ris_d;
    logic                      inc_q, inc_d;
    logic                      intr_q, intr_d;
    logic [DATA_WIDTH-1:0]     mr_q [NUM_ALARMS];

    logic                      tick;
    logic [SW-1:0]             set_vec;
    logic [SW-1:0]             icr_clr;
    logic [SW-1:0]             mis;

    // The prescaler rolls over and ticks when it reaches PSR.
    assign tick = en_q & (presc_q == psr_q);

    // Match detection looks at the counter one cycle after a tick-driven
    // increment (inc_q), so an LR load never raises a match by itself.
    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_alarm
        assign mr_sel[gi]  = (word_addr == (A_MR0 + AW'(gi)));
        assign set_vec[gi] = inc_q & (cnt_q == mr_q[gi]);
    end

`ifdef APB_RTC_OVF_IRQ_EN
    // A tick-driven increment that lands on zero was a wrap.
    assign set_vec[NUM_ALARMS] = inc_q & (cnt_q == '0);
`else
    assign set_vec[NUM_ALARMS] = 1'b0;
`endif

    // Prescaler and counter next state; LR load overrides a coincident tick.
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        inc_d   = 1'b0;
        if (en_q) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            cnt_d = cnt_q + 1'b1;
            inc_d = 1'b1;
        end
        if (psr_wr) begin
            presc_d = '0;
        end
        if (lr_wr) begin
            cnt_d   = PWDATA;
            presc_d = '0;
            inc_d   = 1'b0;
        end
    end

    // Control, mask and status next state; a set event beats a clear.
    always_comb begin
        en_d    = cr_wr   ? PWDATA[0]                      : en_q;
        psr_d   = psr_wr  ? PWDATA[PRESCALE_WIDTH-1:0]     : psr_q;
        imsc_d  = imsc_wr ? (PWDATA[SW-1:0] & STAT_MASK)   : imsc_q;
        icr_clr = icr_wr  ? PWDATA[SW-1:0]                 : '0;
        ris_d   = ((ris_q & ~icr_clr) | set_vec) & STAT_MASK;
    end

    assign mis    = ris_q & imsc_q;
    assign intr_d = |mis;
    assign INTR   = intr_q;

    // Core state registers with asynchronous active-low reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q   <= '0;
            presc_q <= '0;
            psr_q   <= '0;
            en_q    <= 1'b0;
            imsc_q  <= '0;
            ris_q   <= '0;
            inc_q   <= 1'b0;
            intr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            psr_q   <= psr_d;
            en_q    <= en_d;
            imsc_q  <= imsc_d;
            ris_q   <= ris_d;
            inc_q   <= inc_d;
            intr_q  <= intr_d;
        end
    end

    // Match value registers, one per alarm channel.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int n = 0; n < NUM_ALARMS; n++) begin
                mr_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_ALARMS; n++) begin
                if (wr_ok && mr_sel[n]) begin
                    mr_q[n] <= PWDATA;
                end
            end
        end
    end

    // Combinational read mux, driven only during a read access phase.
    always_comb begin
        PRDATA = '0;
        if (PRESETn && access && !PWRITE) begin
            if (sel_dr)   PRDATA = cnt_q;
            if (sel_cr)   PRDATA = DATA_WIDTH'(en_q);
            if (sel_psr)  PRDATA = DATA_WIDTH'(psr_q);
            if (sel_imsc) PRDATA = DATA_WIDTH'(imsc_q);
            if (sel_ris)  PRDATA = DATA_WIDTH'(ris_q);
            if (sel_mis)  PRDATA = DATA_WIDTH'(mis);
            for (int n = 0; n < NUM_ALARMS; n++) begin
                if (mr_sel[n]) PRDATA = mr_q[n];
            end
        end
    end

endmodule
